// File: rtl/pcs_eb_pkg.sv
// Shared types and Gray-code helpers for the elastic-buffer write controller.
package pcs_eb_pkg;

    localparam int unsigned EB_AW = 4;
    localparam int unsigned GW    = 32;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } eb_state_e;

    // Works on any width up to GW: callers zero-extend in and truncate out.
    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits leave the running XOR unaffected.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = int'(GW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pcs_sync_2ff.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus.
module pcs_sync_2ff #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // Two-stage capture into the local clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pcs_eb_wr_ctrl.sv
// Write-side controller for the PCS clock-compensation elastic buffer.
module pcs_eb_wr_ctrl
    import pcs_eb_pkg::*;
#(
    parameter int unsigned AW       = EB_AW,
    parameter int unsigned HI_MARK  = 12,
    parameter int unsigned INIT_CYC = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_del,
    input  logic          clr_err,
    input  logic [AW:0]   rd_gray_async,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW:0]   wr_gray,
    output logic [AW:0]   fill,
    output logic          full,
    output logic          almost_full,
    output logic          drop_pulse,
    output logic          ptr_err
);

    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = $clog2(INIT_CYC + 1);

    eb_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic            ptr_err_q;
    logic [PW-1:0]   wr_bin_q;
    logic [PW-1:0]   wr_bin_d;
    logic [PW-1:0]   wr_gray_q;
    logic [PW-1:0]   wr_gray_d;
    logic [PW-1:0]   rd_gray_s;
    logic [PW-1:0]   rd_bin;
    logic            accept;
    logic            drop;

    pcs_sync_2ff #(.W(PW)) u_rd_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rd_gray_async),
        .q_o   (rd_gray_s)
    );

    // Fill level and status flags from the write pointer and synchronised read pointer.
    assign rd_bin      = PW'(gray2bin(GW'(rd_gray_s)));
    assign fill        = wr_bin_q - rd_bin;
    assign full        = (fill == PW'(DEPTH));
    assign almost_full = (fill >= PW'(HI_MARK));

    // Handshake: deletable words above the high mark are swallowed without taking a slot.
    assign in_ready   = (state_q == ST_RUN) && !full;
    assign accept     = in_valid && in_ready;
    assign drop       = accept && in_del && almost_full;
    assign wr_en      = accept && !drop;
    assign drop_pulse = drop;

    // Next pointer values; Gray is derived from the incremented binary so it is glitch-free.
    assign wr_bin_d  = wr_bin_q + PW'(1);
    assign wr_gray_d = PW'(bin2gray(GW'(wr_bin_d)));

    // Write pointer registers, advanced only on an actual RAM write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
        end else if (wr_en) begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
        end
    end

    // Control FSM: settle the synchroniser, run, and lock out on pointer inconsistency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= CW'(INIT_CYC - 1);
            ptr_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_RUN: begin
                    if (fill > PW'(DEPTH)) begin
                        state_q   <= ST_ERR;
                        ptr_err_q <= 1'b1;
                    end
                end
                ST_ERR: begin
                    if (clr_err) begin
                        state_q   <= ST_INIT;
                        cnt_q     <= CW'(INIT_CYC - 1);
                        ptr_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign wr_addr = wr_bin_q[AW-1:0];
    assign wr_gray = wr_gray_q;
    assign ptr_err = ptr_err_q;

endmodule

// File: tb/tb_pcs_eb_wr_ctrl.sv
// Self-checking bench for the elastic-buffer write controller.
module tb_pcs_eb_wr_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned PW = AW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_del = 1'b0;
    logic          clr_err = 1'b0;
    logic [PW-1:0] rd_gray_async = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_gray;
    logic [PW-1:0] fill;
    logic          full;
    logic          almost_full;
    logic          drop_pulse;
    logic          ptr_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: write pointer, read-sync pipeline, FSM state, init counter, error flag.
    int wr_m, s1_m, s2_m, rd_set, st_m, cnt_m, err_m;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] sb_e;

    pcs_eb_wr_ctrl #(.AW(AW), .HI_MARK(12), .INIT_CYC(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_del        (in_del),
        .clr_err       (clr_err),
        .rd_gray_async (rd_gray_async),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_gray       (wr_gray),
        .fill          (fill),
        .full          (full),
        .almost_full   (almost_full),
        .drop_pulse    (drop_pulse),
        .ptr_err       (ptr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, simulation stuck");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b & 31);
        return v ^ (v >> 1);
    endfunction

    function automatic int fill_m();
        return (wr_m - s2_m) & 31;
    endfunction

    // Scoreboard: every RAM write must match the next expected address.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_write: unexpected write at wr_addr=%0d", wr_addr);
            end else begin
                sb_e = exp_q.pop_front();
                if (wr_addr !== sb_e) begin
                    errors++;
                    $display("FAIL sb_write: wr_addr got %0d want %0d", wr_addr, sb_e);
                end
            end
        end
    end

    task automatic model_reset();
        wr_m = 0; s1_m = 0; s2_m = 0; rd_set = 0;
        st_m = 0; cnt_m = 3; err_m = 0;
        exp_q.delete();
    endtask

    // One clock of stimulus, checked against the model, then the model steps with the edge.
    task automatic drive_cycle(input logic v, input logic d, input logic c, input string tag);
        int   f;
        logic full_e, af_e, rdy_e, acc, drp, we;
        in_valid = v; in_del = d; clr_err = c;
        rd_gray_async = to_gray(rd_set);
        #1;
        f      = fill_m();
        full_e = (f == 16);
        af_e   = (f >= 12);
        rdy_e  = (st_m == 1) && !full_e;
        acc    = v && rdy_e;
        drp    = acc && d && af_e;
        we     = acc && !drp;
        checks++;
        if (in_ready !== rdy_e) begin errors++; $display("FAIL %s in_ready: got %b want %b", tag, in_ready, rdy_e); end
        checks++;
        if (wr_en !== we) begin errors++; $display("FAIL %s wr_en: got %b want %b", tag, wr_en, we); end
        checks++;
        if (drop_pulse !== drp) begin errors++; $display("FAIL %s drop_pulse: got %b want %b", tag, drop_pulse, drp); end
        checks++;
        if (fill !== PW'(f)) begin errors++; $display("FAIL %s fill: got %0d want %0d", tag, fill, f); end
        checks++;
        if (full !== full_e) begin errors++; $display("FAIL %s full: got %b want %b", tag, full, full_e); end
        checks++;
        if (almost_full !== af_e) begin errors++; $display("FAIL %s almost_full: got %b want %b", tag, almost_full, af_e); end
        checks++;
        if (wr_gray !== to_gray(wr_m)) begin errors++; $display("FAIL %s wr_gray: got %b want %b", tag, wr_gray, to_gray(wr_m)); end
        checks++;
        if (wr_addr !== AW'(wr_m)) begin errors++; $display("FAIL %s wr_addr: got %0d want %0d", tag, wr_addr, wr_m & 15); end
        checks++;
        if (ptr_err !== err_m[0]) begin errors++; $display("FAIL %s ptr_err: got %b want %b", tag, ptr_err, err_m[0]); end
        if (we) exp_q.push_back(AW'(wr_m));
        @(posedge clk);
        case (st_m)
            0: if (cnt_m == 0) st_m = 1; else cnt_m--;
            1: if (f > 16) begin st_m = 2; err_m = 1; end
            default: if (c) begin st_m = 0; cnt_m = 3; err_m = 0; end
        endcase
        if (we) wr_m = (wr_m + 1) & 31;
        s2_m = s1_m;
        s1_m = rd_set;
        #1;
        in_valid = 1'b0; in_del = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b0 || drop_pulse !== 1'b0) begin
            errors++; $display("FAIL reset_hs: in_ready=%b wr_en=%b drop=%b want 0", in_ready, wr_en, drop_pulse);
        end
        checks++;
        if (fill !== 5'd0 || full !== 1'b0 || almost_full !== 1'b0) begin
            errors++; $display("FAIL reset_fill: fill=%0d full=%b af=%b want 0", fill, full, almost_full);
        end
        checks++;
        if (wr_addr !== 4'd0 || wr_gray !== 5'b00000 || ptr_err !== 1'b0) begin
            errors++; $display("FAIL reset_ptr: wr_addr=%0d wr_gray=%b ptr_err=%b want 0", wr_addr, wr_gray, ptr_err);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b0, "reset_init");
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b want 1", in_ready); end
    endtask

    task automatic test_fill_to_full();
        logic [PW-1:0] gseq [16] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                                     5'b00111, 5'b00101, 5'b00100, 5'b01100,
                                     5'b01101, 5'b01111, 5'b01110, 5'b01010,
                                     5'b01011, 5'b01001, 5'b01000, 5'b11000};
        rd_set = 0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 1'b0, (i == 0), "fill");
            checks++;
            if (wr_gray !== gseq[i]) begin errors++; $display("FAIL fill_gray[%0d]: got %b want %b", i, wr_gray, gseq[i]); end
        end
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || fill !== 5'd16) begin
            errors++; $display("FAIL fill_full: full=%b in_ready=%b fill=%0d want 1/0/16", full, in_ready, fill);
        end
        checks++;
        if (ptr_err !== 1'b0) begin errors++; $display("FAIL fill_clr_ignored: ptr_err=%b want 0", ptr_err); end
        drive_cycle(1'b1, 1'b0, 1'b0, "fill_blocked");
    endtask

    task automatic test_idle_deletion();
        rd_set = 5;
        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, "del_settle");
        checks++;
        if (fill !== 5'd11) begin errors++; $display("FAIL del_fill11: got %0d want 11", fill); end
        drive_cycle(1'b1, 1'b1, 1'b0, "del_below_mark");
        checks++;
        if (fill !== 5'd12 || wr_gray !== 5'b11001) begin
            errors++; $display("FAIL del_below_write: fill=%0d wr_gray=%b want 12/11001", fill, wr_gray);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, "del_at_mark");
        checks++;
        if (fill !== 5'd12 || wr_gray !== 5'b11001) begin
            errors++; $display("FAIL del_drop_ptr: fill=%0d wr_gray=%b want 12/11001", fill, wr_gray);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, "del_keep");
        checks++;
        if (fill !== 5'd13) begin errors++; $display("FAIL del_keep_fill: got %0d want 13", fill); end
        rd_set = 2;
        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, "del_to_full");
        drive_cycle(1'b1, 1'b1, 1'b0, "del_when_full");
        checks++;
        if (fill !== 5'd16 || full !== 1'b1) begin
            errors++; $display("FAIL del_full_nodrop: fill=%0d full=%b want 16/1", fill, full);
        end
    endtask

    task automatic test_wrap_drain();
        logic seen_zero;
        seen_zero = 1'b0;
        rd_set = (wr_m - 3) & 31;
        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, "wrap_pre");
        rd_set = (wr_m - 2) & 31;
        drive_cycle(1'b0, 1'b0, 1'b0, "wrap_pre");
        for (int i = 0; i < 40; i++) begin
            rd_set = (wr_m - 1) & 31;
            drive_cycle(1'b1, 1'b0, 1'b0, "wrap");
            checks++;
            if (fill !== 5'd3 || full !== 1'b0 || ptr_err !== 1'b0) begin
                errors++; $display("FAIL wrap_steady[%0d]: fill=%0d full=%b ptr_err=%b want 3/0/0", i, fill, full, ptr_err);
            end
            if (wr_gray === 5'b00000) seen_zero = 1'b1;
        end
        checks++;
        if (seen_zero !== 1'b1) begin errors++; $display("FAIL wrap_seen: wr pointer never wrapped to 0"); end
    endtask

    task automatic test_ptr_err();
        rd_set = (wr_m + 2) & 31;
        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, "err_sync");
        checks++;
        if (fill !== 5'd30) begin errors++; $display("FAIL err_fill30: got %0d want 30", fill); end
        drive_cycle(1'b1, 1'b0, 1'b0, "err_with_write");
        checks++;
        if (ptr_err !== 1'b1 || in_ready !== 1'b0 || wr_gray !== 5'b10110) begin
            errors++; $display("FAIL err_enter: ptr_err=%b in_ready=%b wr_gray=%b want 1/0/10110", ptr_err, in_ready, wr_gray);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, "err_sticky");
        rd_set = wr_m;
        drive_cycle(1'b0, 1'b0, 1'b1, "err_clr");
        checks++;
        if (ptr_err !== 1'b0) begin errors++; $display("FAIL err_cleared: ptr_err=%b want 0", ptr_err); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, "err_reinit");
            checks++;
            if (in_ready !== (i == 3)) begin
                errors++; $display("FAIL err_reinit_ready[%0d]: got %b want %b", i, in_ready, (i == 3));
            end
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b0 || fill !== 5'd0 || wr_gray !== 5'b00000 || wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: in_ready=%b wr_en=%b fill=%0d wr_gray=%b wr_addr=%0d want all 0",
                     in_ready, wr_en, fill, wr_gray, wr_addr);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_to_full();
        test_idle_deletion();
        test_wrap_drain();
        test_ptr_err();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expected writes never seen", exp_q.size()); end
        @(posedge clk);
        #1;
        test_async_reset();
        drive_cycle(1'b0, 1'b0, 1'b0, "post_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
